// File: rtl/reset_sequencer.sv
// Ordered reset release: holds all stages, then frees them one at a time,
// waiting for each stage's ready plus a fixed gap before moving on.
module reset_sequencer #(
  parameter int NSTAGES        = 4,
  parameter int SW_HOLD        = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST_REQ,
  input  logic [NSTAGES-1:0] STAGE_READY,
  output logic [NSTAGES-1:0] STAGE_RST,
  output logic               ALL_READY,
  output logic               TIMEOUT_ERR,
  output logic               BUSY
);

  localparam int MAX_HG  = (SW_HOLD > GAP_CYCLES) ? SW_HOLD : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(SW_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NSTAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NSTAGES-1:0] stage_rst_nxt;
  logic               all_ready_nxt;
  logic               timeout_err_nxt;
  logic               busy_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_HOLD;
      idx         <= '0;
      cnt         <= '0;
      STAGE_RST   <= '1;
      ALL_READY   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      BUSY        <= 1'b1;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      STAGE_RST   <= stage_rst_nxt;
      ALL_READY   <= all_ready_nxt;
      TIMEOUT_ERR <= timeout_err_nxt;
      BUSY        <= busy_nxt;
    end
  end

  // Counter restarts on every state change; a software request overrides all.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt + 1'b1;
    stage_rst_nxt   = STAGE_RST;
    all_ready_nxt   = 1'b0;
    timeout_err_nxt = TIMEOUT_ERR;
    busy_nxt        = 1'b1;

    if (SW_RST_REQ) begin
      state_nxt       = S_HOLD;
      idx_nxt         = '0;
      cnt_nxt         = '0;
      stage_rst_nxt   = '1;
      timeout_err_nxt = 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          stage_rst_nxt = '1;
          if (cnt == HOLD_LAST) begin
            stage_rst_nxt[0] = 1'b0;
            state_nxt        = S_WAIT;
            idx_nxt          = '0;
            cnt_nxt          = '0;
          end
        end
        S_WAIT: begin
          // Ready on the final timeout edge still counts as success.
          if (STAGE_READY[idx]) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt     = S_DONE;
              all_ready_nxt = 1'b1;
              busy_nxt      = 1'b0;
            end else begin
              state_nxt = S_GAP;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt       = S_ERROR;
            cnt_nxt         = '0;
            stage_rst_nxt   = '1;
            timeout_err_nxt = 1'b1;
            busy_nxt        = 1'b0;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            idx_nxt                = idx + 1'b1;
            stage_rst_nxt[idx_nxt] = 1'b0;
            state_nxt              = S_WAIT;
            cnt_nxt                = '0;
          end
        end
        S_DONE: begin
          cnt_nxt       = cnt;
          all_ready_nxt = &STAGE_READY;
          busy_nxt      = 1'b0;
        end
        S_ERROR: begin
          cnt_nxt       = cnt;
          stage_rst_nxt = '1;
          busy_nxt      = 1'b0;
        end
        default: begin
          state_nxt = S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a cycle-level reference model pushes
// expected outputs, and a negedge monitor pops and compares them.
module tb_reset_sequencer;

  localparam int NSTAGES = 4;
  localparam int SW_HOLD = 8;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 1024;

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_GAP  = 2;
  localparam int P_DONE = 3;
  localparam int P_ERR  = 4;

  typedef struct packed {
    logic [NSTAGES-1:0] stage_rst;
    logic               all_ready;
    logic               timeout_err;
    logic               busy;
  } exp_t;

  logic               CLK;
  logic               RST;
  logic               SW_RST_REQ;
  logic [NSTAGES-1:0] STAGE_READY;
  logic [NSTAGES-1:0] STAGE_RST;
  logic               ALL_READY;
  logic               TIMEOUT_ERR;
  logic               BUSY;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  int   m_phase;
  int   m_age;
  int   m_released;
  bit   m_all;
  bit   m_err;

  reset_sequencer #(
    .NSTAGES(NSTAGES),
    .SW_HOLD(SW_HOLD),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SW_RST_REQ(SW_RST_REQ),
    .STAGE_READY(STAGE_READY),
    .STAGE_RST(STAGE_RST),
    .ALL_READY(ALL_READY),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: phase, edges since phase entry, and how many stages are free.
  function automatic void modelReset();
    m_phase    = P_HOLD;
    m_age      = 0;
    m_released = 0;
    m_all      = 1'b0;
    m_err      = 1'b0;
  endfunction

  function automatic void modelEdge(input logic sw, input logic [NSTAGES-1:0] rdy);
    if (sw) begin
      modelReset();
      return;
    end
    m_age++;
    case (m_phase)
      P_HOLD: if (m_age == SW_HOLD) begin
        m_released = 1;
        m_phase    = P_WAIT;
        m_age      = 0;
      end
      P_WAIT: begin
        if (rdy[m_released-1]) begin
          if (m_released == NSTAGES) begin
            m_phase = P_DONE;
            m_all   = 1'b1;
          end else begin
            m_phase = P_GAP;
            m_age   = 0;
          end
        end else if (m_age == TIMEOUT) begin
          m_phase    = P_ERR;
          m_released = 0;
          m_err      = 1'b1;
          m_all      = 1'b0;
        end
      end
      P_GAP: if (m_age == GAP) begin
        m_released++;
        m_phase = P_WAIT;
        m_age   = 0;
      end
      P_DONE: m_all = &rdy;
      default: ;
    endcase
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    logic [NSTAGES-1:0] ones;
    ones          = '1;
    e.stage_rst   = ones << m_released;
    e.all_ready   = m_all;
    e.timeout_err = m_err;
    e.busy        = (m_phase == P_HOLD) || (m_phase == P_WAIT) || (m_phase == P_GAP);
    return e;
  endfunction

  // Drive the inputs for the next edge, queue the expectation, then advance the model.
  task automatic applyStimulus(input logic rst, input logic sw, input logic [NSTAGES-1:0] rdy);
    RST         = rst;
    SW_RST_REQ  = sw;
    STAGE_READY = rdy;
    if (RST) modelReset();
    exp_q.push_back(modelOut());
    @(posedge CLK);
    #1;
    if (RST) modelReset();
    else modelEdge(SW_RST_REQ, STAGE_READY);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t got;
    got = '{STAGE_RST, ALL_READY, TIMEOUT_ERR, BUSY};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL outputs vec %0d t=%0t: got stage_rst=%h all_ready=%b timeout_err=%b busy=%b, expected stage_rst=%h all_ready=%b timeout_err=%b busy=%b",
               vectors, $time, got.stage_rst, got.all_ready, got.timeout_err, got.busy,
               e.stage_rst, e.all_ready, e.timeout_err, e.busy);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic runCycles(input int n, input logic [NSTAGES-1:0] rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, rdy);
  endtask

  task automatic expectPhase(input int phase, input string name);
    vectors++;
    if (m_phase != phase) begin
      miscompares++;
      $display("[TB] FAIL %s: model phase %0d, required %0d", name, m_phase, phase);
    end
  endtask

  initial begin
    int guard;
    logic [NSTAGES-1:0] rdy;
    RST         = 1'b1;
    SW_RST_REQ  = 1'b0;
    STAGE_READY = '0;
    modelReset();
    @(posedge CLK);
    #1;

    $display("[TB] reset then nominal sequence");
    applyStimulus(1'b1, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'hF);
    runCycles(70, 4'hF);
    expectPhase(P_DONE, "nominal_done");

    $display("[TB] stage 1 never ready: timeout, then software restart");
    applyStimulus(1'b0, 1'b1, 4'b1101);
    runCycles(SW_HOLD + GAP + 2 + TIMEOUT + 10, 4'b1101);
    expectPhase(P_ERR, "timeout_error");
    applyStimulus(1'b0, 1'b1, 4'hF);
    runCycles(70, 4'hF);
    expectPhase(P_DONE, "restart_done");

    $display("[TB] stage 2 ready on the final timeout edge");
    applyStimulus(1'b0, 1'b1, 4'b1011);
    rdy   = 4'b1011;
    guard = 0;
    while (m_phase != P_DONE && guard < 3000) begin
      if (m_phase == P_WAIT && m_released == 3 && m_age == TIMEOUT - 1) rdy = 4'hF;
      applyStimulus(1'b0, 1'b0, rdy);
      guard++;
    end
    expectPhase(P_DONE, "late_ready_done");
    runCycles(3, 4'hF);

    $display("[TB] software request in DONE");
    applyStimulus(1'b0, 1'b1, 4'hF);
    runCycles(70, 4'hF);

    $display("[TB] asynchronous reset mid-gap");
    applyStimulus(1'b0, 1'b1, 4'hF);
    guard = 0;
    while (!(m_phase == P_GAP && m_released == 2 && m_age == 8) && guard < 200) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      guard++;
    end
    expectPhase(P_GAP, "reached_gap");
    applyStimulus(1'b1, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'hF);
    runCycles(70, 4'hF);

    $display("[TB] ready drop in DONE");
    runCycles(2, 4'hF);
    runCycles(3, 4'b0111);
    runCycles(4, 4'hF);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      logic [NSTAGES-1:0] rr;
      r  = ($urandom_range(0, 399) == 0);
      s  = ($urandom_range(0, 149) == 0);
      rr = NSTAGES'($urandom) | NSTAGES'($urandom) | NSTAGES'($urandom);
      applyStimulus(r, s, rr);
    end
    runCycles(3, 4'hF);

    repeat (2) @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the synchronous reset-synchroniser stage; its RST input is that stage's synchronised output.
- Drives NSTAGES ordered, active-high reset outputs, e.g. clock gen, memory controller, DMA, user logic.
- Releases the stages one at a time. Each release waits for that stage's ready/lock indication, then a fixed gap.
- Reports completion and timeout, and supports a software-requested full re-sequence.

Parameters:
NSTAGES, 4, number of sequenced reset outputs (>=1)
SW_HOLD, 8, cycles all resets stay asserted before stage 0 releases (>=1)
GAP_CYCLES, 16, idle cycles between stage k ready and stage k+1 release (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles to wait for a stage's ready (>=2)

Ports:
CLK  input  1  clock; all logic on posedge
RST  input  1  asynchronous, active-high reset (fed from the synchronised reset stage)
SW_RST_REQ  input  1  software re-sequence request, sampled on posedge
STAGE_READY  input  NSTAGES  per-stage ready/lock, synchronous to CLK
STAGE_RST  output  NSTAGES  per-stage reset, active-high, registered
ALL_READY  output  1  all stages released and ready, registered
TIMEOUT_ERR  output  1  sticky: a stage failed to become ready, registered
BUSY  output  1  sequence in progress (HOLD/WAIT/GAP states), registered

Behaviour:
- Reset values while RST=1 (asynchronous):
  - STAGE_RST = all ones, ALL_READY = 0, TIMEOUT_ERR = 0, BUSY = 1.
  - state = HOLD, stage index = 0, counter = 0.
- States: HOLD, WAIT, GAP, DONE, ERROR.
- Counter: a single counter sized for max(SW_HOLD, GAP_CYCLES, TIMEOUT_CYCLES), cleared on every state entry.
- HOLD:
  - All STAGE_RST high; counter increments each edge.
  - On the SW_HOLD-th edge after entry: STAGE_RST[0] goes 0, move to WAIT with index 0.
- WAIT (stage idx released, waiting):
  - If STAGE_READY[idx]=1 on an edge and idx<NSTAGES-1: go to GAP.
  - If STAGE_READY[idx]=1 and idx=NSTAGES-1: go to DONE; ALL_READY goes 1 and BUSY goes 0 on that same edge.
  - Otherwise the counter increments. On the TIMEOUT_CYCLES-th edge after entry with ready still low: go to ERROR.
  - If ready rises on that final edge, ready wins over timeout.
- GAP:
  - Counts GAP_CYCLES edges.
  - On the last one: idx increments, STAGE_RST[idx] goes 0, return to WAIT.
  - Release spacing between consecutive stages with ready tied high = GAP_CYCLES+1 cycles.
- Release ordering: STAGE_RST bits deassert strictly in index order. A released bit stays 0 until HOLD or ERROR is entered.
- DONE:
  - ALL_READY is registered as &STAGE_READY each edge; a dropped ready deasserts it one cycle later.
  - No automatic re-sequence; BUSY stays 0.
- ERROR:
  - All STAGE_RST reassert on entry; TIMEOUT_ERR = 1 (sticky); ALL_READY = 0; BUSY = 0.
  - Remains in ERROR until SW_RST_REQ.
- SW_RST_REQ=1 on any edge, any state:
  - Next state HOLD, counter = 0, idx = 0.
  - STAGE_RST = all ones, ALL_READY = 0, TIMEOUT_ERR = 0, BUSY = 1 on that edge.
  - Takes priority over every other transition, including timeout and last-stage ready.
  - Held high keeps the block in HOLD with the counter at 0.
- RST asserted mid-sequence: immediate asynchronous return to the reset values above; no glitch on STAGE_RST (bits only go to 1).
- Stage readiness: STAGE_READY bits of unreleased stages are ignored. A released stage's ready dropping during later WAIT/GAP is ignored.

Test Plan:
- Default params, STAGE_READY=4'hF, RST deasserted before edge 1:
  - STAGE_RST[0] falls at edge 8, [1] at 25, [2] at 42, [3] at 59.
  - ALL_READY=1 and BUSY=0 at edge 60.
- STAGE_READY[1] held 0 (others 1): stage 1 released at edge 25; TIMEOUT_ERR=1 and STAGE_RST=4'hF at edge 25+1024; BUSY=0. Then pulse SW_RST_REQ: TIMEOUT_ERR clears and the full sequence restarts.
- STAGE_READY[2] rises exactly on the 1024th WAIT edge: no timeout; proceeds to GAP, completes normally.
- SW_RST_REQ pulse in DONE: STAGE_RST=4'hF and ALL_READY=0 next edge; release times repeat relative to the pulse (+8, +25, ...).
- Assert RST asynchronously midway through GAP after stage 1 released: STAGE_RST=4'hF immediately, before the next edge. After release the sequence restarts from HOLD.
- In DONE, drop STAGE_READY[3] for 3 cycles: ALL_READY low for 3 cycles, lagging 1 cycle; STAGE_RST stays 4'h0.
